// File: rtl/button_event_arbiter_pkg.sv
// Shared types for the button event arbiter: per-button FSM states and the
// queued event record.
package button_pkg;

    localparam int MAX_BUTTONS = 16;
    localparam int EVT_ID_W    = $clog2(MAX_BUTTONS);

    typedef enum logic [1:0] {
        WAIT_REL,
        IDLE,
        PRESSED,
        LONG
    } btn_state_t;

    // Sized for the largest supported button count; narrower configs use the low bits.
    typedef struct packed {
        logic [EVT_ID_W-1:0] id;
        logic                is_long;
    } btn_event_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Valid/ready event stream carrying the id and press type of one button event.
interface button_event_if #(
    parameter int ID_W = 2
) ();
    logic            event_valid;
    logic            event_ready;
    logic [ID_W-1:0] event_id;
    logic            event_long;

    modport master (
        output event_valid,
        output event_id,
        output event_long,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_id,
        input  event_long,
        output event_ready
    );
endinterface

// File: rtl/button_event_arbiter_fifo.sv
// Small synchronous FIFO of button events; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module event_fifo
    import button_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  btn_event_t din,
    input  logic       pop,
    output btn_event_t dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    btn_event_t     mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Classifies debounced button presses as short/long events and serialises them
// onto one valid/ready stream through a round-robin arbiter and a small FIFO.
module button_event_arbiter
    import button_pkg::*;
#(
    parameter int unsigned N_BUTTONS   = 4,
    parameter logic [31:0] LONG_CYCLES = 32'd50000000,
    parameter int unsigned FIFO_DEPTH  = 4,
    localparam int         ID_W        = id_width(N_BUTTONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] buttons,
    button_event_if.master       evt,
    output logic                 overflow,
    input  logic                 clear_overflow
);
    localparam int NB = int'(N_BUTTONS);

    btn_state_t      state_q [NB];
    btn_state_t      state_d [NB];
    logic [31:0]     cnt_q   [NB];
    logic [31:0]     cnt_d   [NB];
    logic [NB-1:0]   raise, raise_long, drop;
    logic [NB-1:0]   pend_vld_q, pend_vld_d;
    logic [NB-1:0]   pend_long_q, pend_long_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic            overflow_q, overflow_d;

    logic [NB-1:0]   grant_vec;
    logic            grant, grant_long;
    int              grant_idx;

    btn_event_t      push_evt, head;
    logic            fifo_full, fifo_empty, pop, can_push;
    logic            unused_id_bits;

    // Per-button FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= WAIT_REL;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                WAIT_REL: if (!buttons[i]) state_d[i] = IDLE;
                IDLE:     if (buttons[i])  state_d[i] = PRESSED;
                PRESSED: begin
                    if (!buttons[i])                         state_d[i] = IDLE;
                    else if (cnt_q[i] == LONG_CYCLES - 1'b1) state_d[i] = LONG;
                end
                LONG:     if (!buttons[i]) state_d[i] = IDLE;
                default:  state_d[i] = WAIT_REL;
            endcase
        end
    end

    // Counter saturates at LONG_CYCLES-1 because the FSM leaves PRESSED there.
    always_comb begin
        raise      = '0;
        raise_long = '0;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = cnt_q[i];
            case (state_q[i])
                IDLE: if (buttons[i]) cnt_d[i] = '0;
                PRESSED: begin
                    if (!buttons[i]) begin
                        raise[i] = 1'b1;
                    end else if (cnt_q[i] == LONG_CYCLES - 1'b1) begin
                        raise[i]      = 1'b1;
                        raise_long[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-robin grant: first pending slot at or after rr_q, wrapping.
    always_comb begin
        int idx;
        idx        = 0;
        grant      = 1'b0;
        grant_idx  = 0;
        grant_long = 1'b0;
        grant_vec  = '0;
        if (can_push) begin
            for (int k = 0; k < NB; k++) begin
                idx = (int'(rr_q) + k) % NB;
                if (!grant && pend_vld_q[idx]) begin
                    grant          = 1'b1;
                    grant_idx      = idx;
                    grant_long     = pend_long_q[idx];
                    grant_vec[idx] = 1'b1;
                end
            end
        end
        rr_d = rr_q;
        if (grant) begin
            rr_d = (grant_idx == NB - 1) ? '0 : ID_W'(grant_idx + 1);
        end
    end

    // A new event only lands in an empty slot; the occupant is never replaced.
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_long_d = pend_long_q;
        drop        = '0;
        for (int i = 0; i < NB; i++) begin
            if (grant_vec[i]) pend_vld_d[i] = 1'b0;
            if (raise[i]) begin
                if (pend_vld_q[i]) begin
                    drop[i] = 1'b1;
                end else begin
                    pend_vld_d[i]  = 1'b1;
                    pend_long_d[i] = raise_long[i];
                end
            end
        end
        if (|drop)               overflow_d = 1'b1;
        else if (clear_overflow) overflow_d = 1'b0;
        else                     overflow_d = overflow_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld_q <= '0;
            rr_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            rr_q       <= rr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_long_q <= pend_long_d;
    end

    assign pop      = ~fifo_empty & evt.event_ready;
    assign can_push = ~fifo_full | pop;

    always_comb begin
        push_evt         = '0;
        push_evt.id      = EVT_ID_W'(grant_idx);
        push_evt.is_long = grant_long;
    end

    event_fifo #(
        .DEPTH (int'(FIFO_DEPTH))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .din   (push_evt),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Outputs are forced to zero while empty so unwritten storage never leaks out.
    assign evt.event_valid = ~fifo_empty;
    assign evt.event_id    = fifo_empty ? '0   : head.id[ID_W-1:0];
    assign evt.event_long  = fifo_empty ? 1'b0 : head.is_long;
    assign overflow        = overflow_q;
    assign unused_id_bits  = ^head.id;

endmodule
